multi_channel_sound_core: RTL and testbench
===========================================

# multi_channel_sound_core

Parametrised multi-channel audio output core for the SoC sound peripheral. The bus master pushes whole sample frames, one sample per channel, into a shared frame FIFO. A programmable rate generator pops one frame per sample period, and each channel drives its own first-order sigma-delta 1-bit DAC output. A low-watermark interrupt, with explicit acknowledge, replaces the previous fixed-threshold interrupt.

## Interface
- CHANNELS, 2, number of audio channels (1–8)
- SAMPLE_W, 16, unsigned sample width in bits (8–16)
- DEPTH, 512, FIFO depth in frames; must be a power of two, at least 4
- CNT_W, $clog2(DEPTH)+1, frame-count width (derived)

Ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sampleIn  in  CHANNELS*SAMPLE_W  one frame; channel 0 occupies the LSBs
- bufferLoadEn  in  1  pushes sampleIn as one frame
- configLoadEn  in  1  loads all config inputs in the same cycle
- clocksPerSampleIn  in  16  sample period in clk cycles
- watermarkIn  in  CNT_W  low-watermark threshold
- irqEnIn  in  1  interrupt enable
- enableIn  in  1  playback enable
- irqAck  in  1  clears irq and underrun
- frameCount  out  CNT_W  frames currently held in the FIFO
- clocksPerSample  out  16  config readback; resets to 16'd4535 (22050 Hz at 100 MHz)
- watermark  out  CNT_W  config readback; resets to DEPTH/2
- irqEn  out  1  config readback; resets to 0
- enable  out  1  config readback; resets to 0
- irq  out  1  sticky interrupt request; resets to 0
- underrun  out  1  sticky underrun flag; resets to 0
- pwmOut  out  CHANNELS  1-bit DAC outputs; reset to 0

## Operation
- **Push**
  - A frame is written when bufferLoadEn=1 and frameCount<DEPTH.
  - A push while full is dropped silently; frameCount stays at DEPTH.
- **Rate generator**
  - Counter `rc` runs while enable=1 and issues `tick` when rc==clocksPerSample-1, then wraps to 0.
  - clocksPerSample of 0 or 1 produces a tick every cycle.
  - configLoadEn clears rc to 0.
  - enable=0 holds rc at 0.
- **Pop**
  - On tick with frameCount>0, the head frame is loaded into the per-channel sample registers and the FIFO pointer advances.
  - On tick with frameCount==0, the sample registers hold their values (see Configuration).
- **Simultaneous push and pop**
  - Both happen and frameCount is unchanged.
  - Emptiness is judged on the pre-edge frameCount, so a push into an empty FIFO on a tick cycle does not satisfy that tick.
- **Watermark interrupt**
  - A pop that moves frameCount from watermark+1 to watermark sets irq when irqEn=1.
  - irq stays set until irqAck.
  - If irqAck and a set condition occur in the same cycle, set wins.
- **Sigma-delta, per channel**
  - Accumulator is SAMPLE_W+1 bits: acc <= {1'b0, acc[SAMPLE_W-1:0]} + sample.
  - pwmOut[c] is acc[SAMPLE_W] registered.
  - Output duty equals sample / 2^SAMPLE_W.
- **Disable**
  - enable=0 clears all accumulators and forces pwmOut to 0.
  - FIFO contents and sample registers are retained.
- **Reset mid-operation**
  - Everything returns to the reset values listed in the Interface section.
  - The FIFO is emptied: pointers and count go to 0.

## Timing
- Push latency: frameCount increments on the edge after bufferLoadEn.
- Pop: the sample register updates on the edge ending the tick cycle. pwmOut reflects the new sample from the second edge after that.
- irq and underrun assert on the same edge as the triggering pop or tick.
- Config readback outputs update on the edge after configLoadEn.
- Sample period: exactly max(clocksPerSample,1) cycles between ticks while enabled.
- The first tick after enable rises comes clocksPerSample cycles later.

## Configuration
- Macro: SOUND_UNDERRUN_IRQ_EN.
- **Defined**
  - A tick with an empty FIFO while enable=1 sets underrun.
  - It also sets irq when irqEn=1.
  - Both flags are cleared by irqAck.
- **Undefined**
  - underrun is tied to 0.
  - Empty ticks only hold the samples.
  - irq comes from the watermark only.

## Structure
- Shared package `sound_pkg`:
  - reset-default constants for clocksPerSample and enable;
  - typedef `sound_cfg_t`, a packed struct of clocksPerSample, watermark, irqEn and enable;
  - the CNT_W derivation function.
- Sub-module `sigma_delta_dac`, parametrised by SAMPLE_W and instantiated CHANNELS times in a generate loop.
- The FIFO (dual-pointer RAM of CHANNELS*SAMPLE_W-bit words plus count) is written inline.

## Test plan
- **Reset defaults:** assert reset → clocksPerSample=4535, watermark=DEPTH/2, frameCount=0, irq=0, pwmOut=0.
- **Pop cadence:** clocksPerSample=4, enable=1, push 3 frames → ticks every 4 cycles; frameCount goes 3,2,1,0; sample registers match the pushed data in order.
- **Sigma-delta duty:** SAMPLE_W=8, sample 8'h40 → pwmOut[0] high exactly 64 of every 256 cycles; sample 0 → constantly 0.
- **Overflow and simultaneous events:**
  - push DEPTH+1 frames → frameCount=DEPTH and the extra frame is absent from the output;
  - push and tick in the same cycle → count unchanged.
- **Watermark irq:** watermark=2, irqEn=1, fill to 4 → irq rises on the pop from 3 to 2 and not on the pop from 2 to 1; irqAck clears it.
- **Underrun (macro defined):**
  - empty FIFO with a tick → underrun=1, irq=1, samples held;
  - irqAck → both 0;
  - macro undefined → underrun stays 0.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants, config bundle and width helper for the sound core.
// Ports: none (package only).
package sound_pkg;

  localparam logic [15:0] CPS_RST    = 16'd4535;
  localparam logic        ENABLE_RST = 1'b0;
  localparam logic        IRQEN_RST  = 1'b0;

  // watermark is held at 16 bits so the bundle is
  // independent of DEPTH; the top uses the low CNT_W bits.
  typedef struct packed {
    logic [15:0] clocksPerSample;
    logic [15:0] watermark;
    logic        irqEn;
    logic        enable;
  } sound_cfg_t;

  function automatic int cntW(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta 1-bit DAC, one per channel.
// Ports: clk, reset, enable, sample[SAMPLE_W], pwm.
module sigma_delta_dac #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                pwm
);

  logic [SAMPLE_W:0] acc;

  // The MSB is the carry out of the running sum; its
  // density equals sample / 2^SAMPLE_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      pwm <= 1'b0;
    end else if (!enable) begin
      acc <= '0;
      pwm <= 1'b0;
    end else begin
      acc <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, sample};
      pwm <= acc[SAMPLE_W];
    end
  end

endmodule

// File: rtl/multi_channel_sound_core.sv
// Multi-channel sound core: frame FIFO, rate generator, per-channel DACs.
// Ports: clk, reset, sampleIn, bufferLoadEn, config inputs/readback,
// irqAck, frameCount, irq, underrun, pwmOut. Option: SOUND_UNDERRUN_IRQ_EN.
module multi_channel_sound_core
  import sound_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 512,
  parameter int CNT_W    = cntW(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*SAMPLE_W-1:0] sampleIn,
  input  logic                         bufferLoadEn,
  input  logic                         configLoadEn,
  input  logic [15:0]                  clocksPerSampleIn,
  input  logic [CNT_W-1:0]             watermarkIn,
  input  logic                         irqEnIn,
  input  logic                         enableIn,
  input  logic                         irqAck,
  output logic [CNT_W-1:0]             frameCount,
  output logic [15:0]                  clocksPerSample,
  output logic [CNT_W-1:0]             watermark,
  output logic                         irqEn,
  output logic                         enable,
  output logic                         irq,
  output logic                         underrun,
  output logic [CHANNELS-1:0]          pwmOut
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = CHANNELS * SAMPLE_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  sound_cfg_t cfg;
  logic [15:0] rc;
  logic tick;
  logic push;
  logic pop;
  logic wmHit;
  logic irqSet;
  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] headFrame;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic [SAMPLE_W-1:0] sampleReg [CHANNELS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg <= '{clocksPerSample: CPS_RST,
               watermark: 16'(DEPTH / 2),
               irqEn: IRQEN_RST,
               enable: ENABLE_RST};
    end else if (configLoadEn) begin
      cfg <= '{clocksPerSample: clocksPerSampleIn,
               watermark: 16'(watermarkIn),
               irqEn: irqEnIn,
               enable: enableIn};
    end
  end

  // Periods of 0 and 1 both collapse to a tick every cycle.
  assign tick = cfg.enable &&
    (cfg.clocksPerSample <= 16'd1 ||
     rc == cfg.clocksPerSample - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rc <= '0;
    else if (configLoadEn || !cfg.enable || tick)
      rc <= '0;
    else
      rc <= rc + 16'd1;
  end

  assign push = bufferLoadEn && count != FULL;
  assign pop  = tick && count != '0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= sampleIn;
  end

  assign headFrame = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++)
        sampleReg[c] <= '0;
    end else if (pop) begin
      for (int c = 0; c < CHANNELS; c++)
        sampleReg[c] <= headFrame[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Pop that takes the count from watermark+1 down to watermark.
  assign wmHit = pop && cfg.irqEn &&
    16'(count) == cfg.watermark + 16'd1;

`ifdef SOUND_UNDERRUN_IRQ_EN
  logic emptyTick;
  logic underrunReg;

  assign emptyTick = tick && count == '0;
  assign irqSet    = wmHit || (emptyTick && cfg.irqEn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      underrunReg <= 1'b0;
    else if (emptyTick)
      underrunReg <= 1'b1;
    else if (irqAck)
      underrunReg <= 1'b0;
  end

  assign underrun = underrunReg;
`else
  assign irqSet   = wmHit;
  assign underrun = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq <= 1'b0;
    else if (irqSet)
      irq <= 1'b1;
    else if (irqAck)
      irq <= 1'b0;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gDac
    sigma_delta_dac #(
      .SAMPLE_W(SAMPLE_W)
    ) uDac (
      .clk   (clk),
      .reset (reset),
      .enable(cfg.enable),
      .sample(sampleReg[g]),
      .pwm   (pwmOut[g])
    );
  end

  assign frameCount      = count;
  assign clocksPerSample = cfg.clocksPerSample;
  assign watermark       = cfg.watermark[CNT_W-1:0];
  assign irqEn           = cfg.irqEn;
  assign enable          = cfg.enable;

endmodule

// File: tb/tb_multi_channel_sound_core.sv
// Directed bench for multi_channel_sound_core (2 ch, 8-bit, depth 8).
// Ports: none.
module tb_multi_channel_sound_core;

  localparam int CH = 2;
  localparam int SW = 8;
  localparam int DP = 8;
  localparam int CW = 4;

`ifdef SOUND_UNDERRUN_IRQ_EN
  localparam logic UR = 1'b1;
`else
  localparam logic UR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CH*SW-1:0] sampleIn = '0;
  logic bufferLoadEn = 1'b0;
  logic configLoadEn = 1'b0;
  logic [15:0] clocksPerSampleIn = '0;
  logic [CW-1:0] watermarkIn = '0;
  logic irqEnIn = 1'b0;
  logic enableIn = 1'b0;
  logic irqAck = 1'b0;
  logic [CW-1:0] frameCount;
  logic [15:0] clocksPerSample;
  logic [CW-1:0] watermark;
  logic irqEn;
  logic enable;
  logic irq;
  logic underrun;
  logic [CH-1:0] pwmOut;

  int errCnt = 0;
  int chkCnt = 0;
  int hi0;
  int hi1;

  multi_channel_sound_core #(
    .CHANNELS(CH),
    .SAMPLE_W(SW),
    .DEPTH   (DP),
    .CNT_W   (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sampleIn         (sampleIn),
    .bufferLoadEn     (bufferLoadEn),
    .configLoadEn     (configLoadEn),
    .clocksPerSampleIn(clocksPerSampleIn),
    .watermarkIn      (watermarkIn),
    .irqEnIn          (irqEnIn),
    .enableIn         (enableIn),
    .irqAck           (irqAck),
    .frameCount       (frameCount),
    .clocksPerSample  (clocksPerSample),
    .watermark        (watermark),
    .irqEn            (irqEn),
    .enable           (enable),
    .irq              (irq),
    .underrun         (underrun),
    .pwmOut           (pwmOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] f);
    sampleIn = f;
    bufferLoadEn = 1'b1;
    @(negedge clk);
    bufferLoadEn = 1'b0;
  endtask

  task automatic cfgLoad(input logic [15:0] cps,
                         input logic [3:0] wm,
                         input logic ie,
                         input logic en);
    clocksPerSampleIn = cps;
    watermarkIn = wm;
    irqEnIn = ie;
    enableIn = en;
    configLoadEn = 1'b1;
    @(negedge clk);
    configLoadEn = 1'b0;
  endtask

  task automatic ack();
    irqAck = 1'b1;
    @(negedge clk);
    irqAck = 1'b0;
  endtask

  initial begin
    // reset defaults
    @(negedge clk);
    chk("rst_cps", clocksPerSample, 16'd4535);
    chk("rst_wm", watermark, 4);
    chk("rst_cnt", frameCount, 0);
    chk("rst_irq", irq, 0);
    chk("rst_pwm", pwmOut, 0);
    chk("rst_en", enable, 0);
    chk("rst_ur", underrun, 0);
    reset = 1'b0;
    @(negedge clk);

    // pop cadence
    push(16'h2211);
    push(16'h4433);
    push(16'h6655);
    chk("cad_fill", frameCount, 3);
    cfgLoad(16'd4, 4'd0, 1'b0, 1'b1);
    chk("cad_cps", clocksPerSample, 16'd4);
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      chk("cad_hold", frameCount, 3 - i);
      @(negedge clk);
      chk("cad_cnt", frameCount, 2 - i);
      chk("cad_s0", dut.sampleReg[0], 8'h11 + 8'h22 * i);
      chk("cad_s1", dut.sampleReg[1], 8'h22 + 8'h22 * i);
    end
    cfgLoad(16'd4, 4'd0, 1'b0, 1'b0);

    // sigma-delta duty: ch0 0x40, ch1 0x00
    push(16'h0040);
    cfgLoad(16'd2, 4'd0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    hi0 = 0;
    hi1 = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi0 += int'(pwmOut[0]);
      hi1 += int'(pwmOut[1]);
    end
    chk("duty40", hi0, 64);
    chk("duty00", hi1, 0);
    chk("duty_cnt", frameCount, 0);
    cfgLoad(16'd2, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("dis_pwm", pwmOut, 0);
    chk("dis_ur", underrun, UR);
    chk("dis_irq", irq, 0);
    ack();
    chk("ack_ur", underrun, 0);

    // overflow: nine pushes into depth 8
    for (int k = 1; k <= 9; k++)
      push({8'(8'h80 + k), 8'(k)});
    chk("ovf_cnt", frameCount, 8);
    cfgLoad(16'd1, 4'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("ovf_s0", dut.sampleReg[0], k);
      chk("ovf_s1", dut.sampleReg[1], 8'h80 + k);
      chk("ovf_cnt", frameCount, 8 - k);
    end
    @(negedge clk);
    chk("ovf_drop", dut.sampleReg[0], 8);
    cfgLoad(16'd1, 4'd0, 1'b0, 1'b0);
    ack();

    // push on a tick cycle
    push(16'hA0A1);
    push(16'hB0B1);
    cfgLoad(16'd4, 4'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    sampleIn = 16'hC0C1;
    bufferLoadEn = 1'b1;
    @(negedge clk);
    bufferLoadEn = 1'b0;
    chk("sim_cnt", frameCount, 2);
    chk("sim_s0", dut.sampleReg[0], 8'hA1);

    // reset mid-operation
    reset = 1'b1;
    #1;
    chk("mid_cnt", frameCount, 0);
    chk("mid_cps", clocksPerSample, 16'd4535);
    chk("mid_en", enable, 0);
    chk("mid_wm", watermark, 4);
    chk("mid_pwm", pwmOut, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // watermark irq
    cfgLoad(16'd4, 4'd2, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++)
      push(16'h1111 * k[15:0]);
    chk("wm_fill", frameCount, 4);
    cfgLoad(16'd4, 4'd2, 1'b1, 1'b1);
    chk("wm_rb", watermark, 2);
    repeat (4) @(negedge clk);
    chk("wm_c3", frameCount, 3);
    chk("wm_i3", irq, 0);
    repeat (4) @(negedge clk);
    chk("wm_c2", frameCount, 2);
    chk("wm_i2", irq, 1);
    ack();
    chk("wm_ack", irq, 0);
    repeat (3) @(negedge clk);
    chk("wm_c1", frameCount, 1);
    chk("wm_i1", irq, 0);
    cfgLoad(16'd4, 4'd2, 1'b1, 1'b0);

    // underrun on an empty tick
    cfgLoad(16'd2, 4'd2, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("ur_cnt", frameCount, 0);
    chk("ur_flag", underrun, UR);
    chk("ur_irq", irq, UR);
    chk("ur_hold", dut.sampleReg[0], 8'h44);
    cfgLoad(16'd2, 4'd2, 1'b1, 1'b0);
    ack();
    chk("ur_ack", underrun, 0);
    chk("ur_ackirq", irq, 0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
